// File: rtl/rotary_pkg.sv
// Shared types and arithmetic helpers for the rotary encoder bank.
// Both the step path and the host preload path bound values through clampWrap().
package rotary_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        STEP_IDLE    = 2'd0,
        STEP_VALID   = 2'd1,
        STEP_ILLEGAL = 2'd2
    } stepKind_e;

    // Wide signed working type so bound arithmetic never overflows.
    localparam int CALC_W = 40;
    typedef logic signed [CALC_W-1:0] calc_t;
    localparam calc_t CALC_ONE = calc_t'(1);

    function automatic int defaultMax(input int width);
        return (1 << width) - 1;
    endfunction

    function automatic stepKind_e decodeStep(input logic aPrev, input logic bPrev,
                                             input logic aNow, input logic bNow);
        stepKind_e kind;
        kind = STEP_IDLE;
        if ((aPrev != aNow) && (bPrev != bNow))
            kind = STEP_ILLEGAL;
        else if ((aPrev != aNow) || (bPrev != bNow))
            kind = STEP_VALID;
        return kind;
    endfunction

    // A leading B counts up.
    function automatic logic stepDir(input logic aNow, input logic bPrev);
        return (aNow ^ bPrev) ? DIR_UP : DIR_DOWN;
    endfunction

    function automatic calc_t clampWrap(input calc_t x, input calc_t lo, input calc_t hi,
                                        input logic wrapEn);
        calc_t r;
        r = x;
        if (x > hi)
            r = wrapEn ? (lo + (x - hi) - CALC_ONE) : hi;
        else if (x < lo)
            r = wrapEn ? (hi - (lo - x) + CALC_ONE) : lo;
        return r;
    endfunction

endpackage

// File: rtl/rotary_channel.sv
// One encoder: 2-FF sync, per-pin debounce, x4 quadrature decode,
// acceleration window and bounded accumulator with host preload.
module rotary_channel
    import rotary_pkg::*;
#(
    parameter int WIDTH        = 12,
    parameter int INC          = 32,
    parameter int ACCEL_MUL    = 4,
    parameter int ACCEL_CYCLES = 120000,
    parameter int DEBOUNCE     = 4,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = defaultMax(WIDTH),
    parameter int INIT_VAL     = 0,
    parameter int WRAP         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             quadA,
    input  logic             quadB,
    input  logic             loadEn,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] value,
    output logic             changed,
    output logic             dir,
    output logic             illegal
);

    localparam int SUM_W = WIDTH + 2;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int TMR_W = $clog2(ACCEL_CYCLES + 1);

    localparam logic [DB_W-1:0]         DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [TMR_W-1:0]        TMR_FULL  = TMR_W'(ACCEL_CYCLES);
    localparam logic signed [SUM_W-1:0] STEP_BASE = SUM_W'(INC);
    localparam logic signed [SUM_W-1:0] STEP_FAST = SUM_W'(INC * ACCEL_MUL);
    localparam calc_t                   LO        = calc_t'(MIN_VAL);
    localparam calc_t                   HI        = calc_t'(MAX_VAL);
    localparam logic                    WRAP_EN   = (WRAP != 0);

    logic [1:0]      rawPins;
    logic [1:0]      sync0;
    logic [1:0]      sync1;
    logic [1:0]      deb;
    logic [1:0]      debPrev;
    logic [DB_W-1:0] dbCnt [2];

    // Down-counter: non-zero means the previous step is still inside the accel window.
    logic [TMR_W-1:0] accelCnt;

    stepKind_e               kind;
    logic                    upNow;
    logic signed [SUM_W-1:0] stepMag;
    logic signed [SUM_W-1:0] sum;
    calc_t                   sumExt;
    logic [WIDTH-1:0]        stepNext;
    logic [WIDTH-1:0]        loadNext;

    assign rawPins = {quadB, quadA};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0   <= '0;
            sync1   <= '0;
            deb     <= '0;
            debPrev <= '0;
            for (int p = 0; p < 2; p++)
                dbCnt[p] <= '0;
        end else begin
            sync0   <= rawPins;
            sync1   <= sync0;
            debPrev <= deb;
            for (int p = 0; p < 2; p++) begin
                if (sync1[p] == deb[p]) begin
                    dbCnt[p] <= '0;
                end else if (dbCnt[p] == DB_LAST) begin
                    deb[p]   <= ~deb[p];
                    dbCnt[p] <= '0;
                end else begin
                    dbCnt[p] <= dbCnt[p] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        kind     = decodeStep(debPrev[0], debPrev[1], deb[0], deb[1]);
        upNow    = stepDir(deb[0], debPrev[1]);
        stepMag  = ((accelCnt != '0) && (upNow == dir)) ? STEP_FAST : STEP_BASE;
        sum      = $signed({2'b00, value}) + (upNow ? stepMag : -stepMag);
        sumExt   = {{(CALC_W - SUM_W){sum[SUM_W-1]}}, sum};
        stepNext = WIDTH'(clampWrap(sumExt, LO, HI, WRAP_EN));
        loadNext = WIDTH'(clampWrap(calc_t'({1'b0, loadValue}), LO, HI, 1'b0));
    end

    // A load on this channel swallows any step decoded in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value    <= WIDTH'(INIT_VAL);
            changed  <= 1'b0;
            dir      <= 1'b0;
            illegal  <= 1'b0;
            accelCnt <= '0;
        end else begin
            changed <= 1'b0;
            if (accelCnt != '0)
                accelCnt <= accelCnt - TMR_W'(1);
            if (kind == STEP_ILLEGAL)
                illegal <= 1'b1;
            if (loadEn) begin
                value   <= loadNext;
                changed <= (loadNext != value);
                illegal <= 1'b0;
            end else if (kind == STEP_VALID) begin
                value    <= stepNext;
                changed  <= (stepNext != value);
                dir      <= upNow;
                accelCnt <= TMR_FULL;
            end
        end
    end

endmodule

// File: rtl/rotary_bank.sv
// Multi-channel rotary encoder front end: one rotary_channel per encoder,
// plus preload demux and packing of the per-channel outputs.
module rotary_bank
    import rotary_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 12,
    parameter int INC          = 32,
    parameter int ACCEL_MUL    = 4,
    parameter int ACCEL_CYCLES = 120000,
    parameter int DEBOUNCE     = 4,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = defaultMax(WIDTH),
    parameter int INIT_VAL     = 0,
    parameter int WRAP         = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         quad_a,
    input  logic [CHANNELS-1:0]         quad_b,
    input  logic                        load,
    input  logic [$clog2(CHANNELS)-1:0] load_chan,
    input  logic [WIDTH-1:0]            load_value,
    output logic [CHANNELS*WIDTH-1:0]   value,
    output logic [CHANNELS-1:0]         changed,
    output logic [CHANNELS-1:0]         dir,
    output logic [CHANNELS-1:0]         illegal
);

    logic [CHANNELS-1:0] loadHit;

    for (genvar n = 0; n < CHANNELS; n++) begin : gCh
        // Out-of-range channel numbers match no instance and are dropped.
        assign loadHit[n] = load && (int'(load_chan) == n);

        rotary_channel #(
            .WIDTH        (WIDTH),
            .INC          (INC),
            .ACCEL_MUL    (ACCEL_MUL),
            .ACCEL_CYCLES (ACCEL_CYCLES),
            .DEBOUNCE     (DEBOUNCE),
            .MIN_VAL      (MIN_VAL),
            .MAX_VAL      (MAX_VAL),
            .INIT_VAL     (INIT_VAL),
            .WRAP         (WRAP)
        ) uChannel (
            .clk       (clk),
            .rst       (reset),
            .quadA     (quad_a[n]),
            .quadB     (quad_b[n]),
            .loadEn    (loadHit[n]),
            .loadValue (load_value),
            .value     (value[n*WIDTH +: WIDTH]),
            .changed   (changed[n]),
            .dir       (dir[n]),
            .illegal   (illegal[n])
        );
    end

endmodule

// File: tb/tb_rotary_bank.sv
// Directed bench for rotary_bank: a clamping instance and a wrapping instance
// share clock and reset; expectations are hand-computed from the quadrature rules.
module tb_rotary_bank;

    localparam int CH   = 4;
    localparam int W    = 12;
    localparam int AC   = 200;
    localparam int SLOW = AC + 10;
    localparam int FAST = 100;

    logic clk = 1'b0;
    logic reset;

    logic [CH-1:0]   qa, qb, qaW, qbW;
    logic            load, loadW;
    logic [1:0]      loadChan, loadChanW;
    logic [W-1:0]    loadValue, loadValueW;
    logic [CH*W-1:0] value, valueW;
    logic [CH-1:0]   changed, dir, illegal;
    logic [CH-1:0]   changedW, dirW, illegalW;

    int checks = 0;
    int errors = 0;
    int chg0   = 0;
    int expV;
    int expChg;
    int snap;

    rotary_bank #(.CHANNELS(CH), .WIDTH(W), .ACCEL_CYCLES(AC), .WRAP(0)) dutClamp (
        .clk(clk), .reset(reset), .quad_a(qa), .quad_b(qb),
        .load(load), .load_chan(loadChan), .load_value(loadValue),
        .value(value), .changed(changed), .dir(dir), .illegal(illegal)
    );

    rotary_bank #(.CHANNELS(CH), .WIDTH(W), .ACCEL_CYCLES(AC), .WRAP(1)) dutWrap (
        .clk(clk), .reset(reset), .quad_a(qaW), .quad_b(qbW),
        .load(loadW), .load_chan(loadChanW), .load_value(loadValueW),
        .value(valueW), .changed(changedW), .dir(dirW), .illegal(illegalW)
    );

    always #5 clk = ~clk;

    // Every wait goes through here, so each one-cycle changed pulse on ch0 is seen once.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (changed[0]) chg0++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] v(input int ch);
        return 32'(value[ch*W +: W]);
    endfunction

    function automatic logic [31:0] vW(input int ch);
        return 32'(valueW[ch*W +: W]);
    endfunction

    // Advance one quadrature state; A leading B is up.
    task automatic stepPins(input int ch, input logic up);
        if ((qa[ch] == qb[ch]) == up) qa[ch] = ~qa[ch];
        else                          qb[ch] = ~qb[ch];
    endtask

    task automatic stepPinsW(input int ch, input logic up);
        if ((qaW[ch] == qbW[ch]) == up) qaW[ch] = ~qaW[ch];
        else                            qbW[ch] = ~qbW[ch];
    endtask

    task automatic doReset();
        qa = '0; qb = '0; qaW = '0; qbW = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        qa = '0; qb = '0; qaW = '0; qbW = '0;
        load = 1'b0; loadChan = '0; loadValue = '0;
        loadW = 1'b0; loadChanW = '0; loadValueW = '0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);

        for (int c = 0; c < CH; c++) check("reset value", v(c), 32'd0);
        check("reset changed", 32'(changed), 32'd0);
        check("reset dir", 32'(dir), 32'd0);
        check("reset illegal", 32'(illegal), 32'd0);

        // One clean up step on ch0: value lands 7 edges after the pin change.
        stepPins(0, 1'b1);
        tick(6);
        check("step early value", v(0), 32'd0);
        check("step early changed", 32'(changed), 32'd0);
        tick(1);
        check("step value", v(0), 32'd32);
        check("step changed", 32'(changed), 32'd1);
        check("step dir", 32'(dir), 32'd1);
        tick(1);
        check("step changed drop", 32'(changed), 32'd0);
        for (int c = 1; c < CH; c++) check("step others", v(c), 32'd0);

        // Three-cycle glitch on A never survives the debounce.
        snap = chg0;
        qa[0] = 1'b0;
        tick(3);
        qa[0] = 1'b1;
        tick(15);
        check("glitch value", v(0), 32'd32);
        check("glitch changed", 32'(chg0 - snap), 32'd0);

        // Slow climb from 0 with clamping at 4095.
        doReset();
        expV = 0;
        expChg = 0;
        snap = chg0;
        for (int i = 0; i < 130; i++) begin
            stepPins(0, 1'b1);
            tick(SLOW);
            if (expV + 32 > 4095) begin
                if (expV != 4095) expChg++;
                expV = 4095;
            end else begin
                expV = expV + 32;
                expChg++;
            end
            check("climb value", v(0), 32'(expV));
        end
        check("climb changed count", 32'(chg0 - snap), 32'(expChg));
        snap = chg0;
        stepPins(0, 1'b1);
        tick(SLOW);
        check("clamp no changed", 32'(chg0 - snap), 32'd0);
        check("clamp value", v(0), 32'd4095);
        check("clamp dir", 32'(dir[0]), 32'd1);

        // Fast steps: first at base size, later same-direction ones accelerated.
        doReset();
        expV = 0;
        for (int i = 0; i < 5; i++) begin
            stepPins(0, 1'b1);
            tick(FAST);
            expV = expV + ((i == 0) ? 32 : 128);
            check("accel value", v(0), 32'(expV));
        end
        stepPins(0, 1'b0);
        tick(FAST);
        check("reverse value", v(0), 32'd512);
        check("reverse dir", 32'(dir[0]), 32'd0);
        stepPins(0, 1'b0);
        tick(FAST);
        check("reverse accel value", v(0), 32'd384);

        // Wrap instance: 4064 -> 0 -> 32 -> 0 -> 4064.
        loadW = 1'b1; loadChanW = 2'd0; loadValueW = 12'd4064;
        tick(1);
        loadW = 1'b0;
        check("wrap load value", vW(0), 32'd4064);
        check("wrap load changed", 32'(changedW[0]), 32'd1);
        stepPinsW(0, 1'b1);
        tick(SLOW);
        check("wrap up over max", vW(0), 32'd0);
        stepPinsW(0, 1'b1);
        tick(SLOW);
        check("wrap up again", vW(0), 32'd32);
        stepPinsW(0, 1'b0);
        tick(SLOW);
        check("wrap down to min", vW(0), 32'd0);
        stepPinsW(0, 1'b0);
        tick(SLOW);
        check("wrap down under min", vW(0), 32'd4064);

        // Simultaneous A+B change on ch2 flags illegal; a load clears it.
        qa[2] = 1'b1;
        qb[2] = 1'b1;
        tick(10);
        check("illegal set", 32'(illegal[2]), 32'd1);
        check("illegal value", v(2), 32'd0);
        load = 1'b1; loadChan = 2'd2; loadValue = 12'd100;
        tick(1);
        load = 1'b0;
        check("illegal cleared", 32'(illegal[2]), 32'd0);
        check("illegal load value", v(2), 32'd100);
        check("illegal load changed", 32'(changed[2]), 32'd1);

        // Load on ch1 lands in the same cycle as its step; ch3 steps normally.
        stepPins(1, 1'b1);
        stepPins(3, 1'b1);
        tick(6);
        load = 1'b1; loadChan = 2'd1; loadValue = 12'd777;
        tick(1);
        load = 1'b0;
        check("load beats step value", v(1), 32'd777);
        check("parallel step value", v(3), 32'd32);
        check("load and step changed", 32'(changed), 32'b1010);
        tick(10);
        check("dropped step value", v(1), 32'd777);
        check("dropped step dir", 32'(dir[1]), 32'd0);

        // Reset mid-debounce on ch3, released with all pins high.
        qa[3] = 1'b0;
        tick(4);
        reset = 1'b1;
        qa = '1;
        qb = '1;
        tick(2);
        check("mid reset value", v(3), 32'd0);
        check("mid reset illegal", 32'(illegal[3]), 32'd0);
        reset = 1'b0;
        tick(4);
        check("release illegal early", 32'(illegal[3]), 32'd0);
        tick(4);
        check("release illegal", 32'(illegal[3]), 32'd1);
        check("release value", v(3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
